mac_frame_accumulator: RTL
==========================

# mac_frame_accumulator

Downstream stage for the pipelined multiply-add unit. It consumes the unit's OUT_WIDTH-bit result stream through a valid/ready input and sums each group of FRAME_LEN accepted samples into one frame sum. It also tracks the frame maximum. The completed frame is presented on a valid/ready output and held until the consumer takes it. The top level drives `in_valid` from a valid shift register aligned to the multiply-add latency.

## Interface

Parameters:
- `WIDTH`, default 8: operand width of the upstream multiply-add.
- `OUT_WIDTH`, default 16: sample width; equals 2*WIDTH.
- `FRAME_LEN`, default 4: samples per frame; legal range 2..256.
- `ACC_WIDTH`: localparam, OUT_WIDTH + $clog2(FRAME_LEN); default 18.

Ports (clock and reset first):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `clear`  in  1  synchronous abort of the current frame.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  OUT_WIDTH  unsigned sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `sum_valid`  out  1  frame result is available.
- `sum_ready`  in  1  consumer takes the frame result.
- `sum_data`  out  ACC_WIDTH  unsigned sum of the frame.
- `max_data`  out  OUT_WIDTH  largest sample in the frame.
- `frame_cnt`  out  8  number of frames delivered; wraps modulo 256.

## Operation

- A sample is accepted when `in_valid && in_ready`.
- The FSM has two states: ACCUM and HOLD.
- **ACCUM**:
  - `in_ready`=1, `sum_valid`=0.
  - On accept: acc <= acc + `in_data`, mx <= max(mx, `in_data`), cnt <= cnt+1.
  - On the accept where cnt == FRAME_LEN-1:
    - `sum_data` <= acc + `in_data`.
    - `max_data` <= max(mx, `in_data`).
    - acc, mx and cnt <= 0.
    - `sum_valid` <= 1, state <= HOLD.
- **HOLD**:
  - `in_ready`=0; `sum_data` and `max_data` are stable.
  - When `sum_ready`=1: `sum_valid` <= 0, `frame_cnt` <= `frame_cnt`+1, state <= ACCUM.
- Arithmetic is unsigned with zero-extension of `in_data` to ACC_WIDTH. ACC_WIDTH is sized so the sum never overflows; no saturation logic.
- **`clear`**:
  - Returns the FSM to ACCUM and zeroes acc, mx, cnt, `sum_valid`, `sum_data` and `max_data`.
  - `frame_cnt` is kept.
  - A sample offered in the same cycle is discarded.
  - `clear` has priority over sample accept and over the HOLD handoff.
- **Reset**:
  - `reset_n`=0 overrides everything, including `clear`.
  - State ACCUM; acc, mx, cnt, `sum_data`, `max_data`, `frame_cnt` = 0; `sum_valid` = 0.
  - `in_ready` = 1 in the first cycle after reset release.
- `in_valid` gaps are allowed in ACCUM; the frame spans any number of cycles.
- `in_ready` is a registered-state decode (state==ACCUM). It does not depend combinationally on `in_valid` or `sum_ready`.

## Timing

- `sum_valid` rises on the edge that accepts the FRAME_LEN-th sample, so it is visible the next cycle.
- Minimum handoff: HOLD lasts at least 1 cycle. With `sum_ready` held at 1, HOLD lasts exactly 1 cycle and `in_ready` is low for that one cycle.
- Peak throughput is therefore FRAME_LEN samples per FRAME_LEN+1 cycles.
- `frame_cnt` increments on the edge where `sum_valid && sum_ready`. It wraps 255 -> 0.
- All outputs are registered or pure state decodes; no input-to-output combinational path.

## Structure

- A shared package `mac_pkg` holds:
  - `WIDTH` and `OUT_WIDTH` constants, shared with the multiply-add unit.
  - The `acc_state_t` enum {ACCUM, HOLD}.
  - `FRAME_CNT_W` = 8.
- The block is a single module with one natural sub-module, `frame_max_tracker`. It is a registered running max with clear/load inputs and is reusable for a future min tracker.
- Estimated size: 150-250 lines.

## Test plan

All scenarios use FRAME_LEN=4.

1. Reset, then samples 1,2,3,4 on consecutive cycles with `sum_ready`=1 -> next cycle `sum_valid`=1, `sum_data`=10, `max_data`=4; one cycle later `frame_cnt`=1 and `in_ready`=1.
2. Four samples of 0xFFFF -> `sum_data`=0x3FFFC, `max_data`=0xFFFF; no overflow.
3. Frame 7,3,9,1 with `sum_ready`=0 for 3 cycles -> `sum_valid`, `sum_data`=20 and `max_data`=9 stable; `in_ready`=0 and offered samples are ignored; `frame_cnt` changes only after `sum_ready`=1.
4. Samples 5,6 then `clear`, then 5,6,7,8 with `in_valid` gaps -> single result `sum_data`=26, `max_data`=8; `frame_cnt` not reset by `clear`.
5. `reset_n`=0 while in HOLD with `frame_cnt`=3 -> next cycle all outputs 0 and `in_ready`=1; a following 2,2,2,2 frame gives `sum_data`=8.
6. Deliver 256 frames back-to-back -> `frame_cnt` wraps to 0; each frame takes exactly 5 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared multiply-add widths and frame accumulator state type
package mac_pkg;

  localparam int WIDTH       = 8;
  localparam int OUT_WIDTH   = 2 * WIDTH;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/frame_max_tracker.sv
// rtl/frame_max_tracker.sv - registered running maximum with clear and load
module frame_max_tracker #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_sample,
  output logic [W-1:0] o_max_nxt
);

  logic [W-1:0] r_max;

  // Combinational next value lets the owner capture the max including the sample accepted this cycle.
  assign o_max_nxt = (i_sample > r_max) ? i_sample : r_max;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_max <= '0;
    end else if (i_clear) begin
      r_max <= '0;
    end else if (i_load) begin
      r_max <= o_max_nxt;
    end
  end

endmodule

// File: rtl/mac_frame_accumulator.sv
// rtl/mac_frame_accumulator.sv - sums FRAME_LEN samples per frame and holds the result until taken
module mac_frame_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH      = mac_pkg::WIDTH,
  parameter int OUT_WIDTH  = mac_pkg::OUT_WIDTH,
  parameter int FRAME_LEN  = 4,
  localparam int ACC_WIDTH = OUT_WIDTH + $clog2(FRAME_LEN)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [OUT_WIDTH-1:0]   in_data,
  output logic                   in_ready,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [ACC_WIDTH-1:0]   sum_data,
  output logic [OUT_WIDTH-1:0]   max_data,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  if (OUT_WIDTH != 2 * WIDTH || FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_cfg
    $error("mac_frame_accumulator: illegal parameter combination");
  end

  acc_state_t             r_state;
  acc_state_t             w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;
  logic [OUT_WIDTH-1:0]   w_max_nxt;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_handoff;

  assign in_ready  = (r_state == ACCUM);
  assign sum_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = w_accept && (r_cnt == LAST_IDX);
  assign w_handoff = sum_valid && sum_ready;
  assign w_acc_nxt = r_acc + ACC_WIDTH'(in_data);

  frame_max_tracker #(
    .W (OUT_WIDTH)
  ) u_max (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (clear || w_last),
    .i_load    (w_accept),
    .i_sample  (in_data),
    .o_max_nxt (w_max_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_last)    w_state_nxt = HOLD;
      HOLD:    if (sum_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // clear outranks both sample accept and the HOLD handoff, but frame_cnt survives it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      sum_data  <= '0;
      max_data  <= '0;
      frame_cnt <= '0;
    end else if (clear) begin
      r_state  <= ACCUM;
      r_acc    <= '0;
      r_cnt    <= '0;
      sum_data <= '0;
      max_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_last) begin
        sum_data <= w_acc_nxt;
        max_data <= w_max_nxt;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_handoff) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
